// File: rtl/servo_pwm_capture_pkg.sv
// Shared constants and helpers for the servo PWM capture block.
// Widths and duty scale match the generator so both ends agree on codes.
package servo_pwm_capture_pkg;

  localparam int CNT_W        = 21;
  localparam int OUT_W        = 20;
  localparam int DUTY_W       = 11;
  localparam int PROD_W       = 28;
  localparam int DUTY_MIN     = 25;
  localparam int DUTY_MAX     = 125;
  localparam int RESET_PERIOD = 1_000_000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

  // A 21-bit count above the 20-bit output range reports all-ones instead of wrapping.
  function automatic logic [OUT_W-1:0] to_out(input logic [CNT_W-1:0] v);
    return v[CNT_W-1] ? {OUT_W{1'b1}} : v[OUT_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] duty_map(input logic [CNT_W-1:0] hi,
                                                 input logic [CNT_W-1:0] pmin,
                                                 input logic [CNT_W-1:0] pmax);
    logic [CNT_W-1:0]  clamped;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] code;
    if (hi < pmin)      clamped = pmin;
    else if (hi > pmax) clamped = pmax;
    else                clamped = hi;
    prod = PROD_W'(clamped - pmin) * PROD_W'(DUTY_MAX - DUTY_MIN);
    code = prod / PROD_W'(pmax - pmin) + PROD_W'(DUTY_MIN);
    return DUTY_W'(code);
  endfunction

endpackage

// File: rtl/servo_pwm_capture_sync.sv
// Two-flop synchroniser for the PWM pin followed by a previous-sample register
// giving single-cycle rise/fall pulses.
module servo_pwm_capture_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic meta;
  logic level;
  logic level_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta    <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      meta    <= pwm_in;
      level   <= meta;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures high time and rising-to-rising period, range-checks
// each period and reports width, period and a 25..125 duty code.
module servo_pwm_capture
  import servo_pwm_capture_pkg::*;
#(
  parameter int PERIOD_MIN = 950_000,
  parameter int PERIOD_MAX = 1_050_000,
  parameter int PULSE_MIN  = 25_000,
  parameter int PULSE_MAX  = 125_000,
  parameter int TIMEOUT    = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [OUT_W-1:0]  pulse_width,
  output logic [OUT_W-1:0]  period,
  output logic [DUTY_W-1:0] duty_code,
  output logic              valid,
  output logic              err,
  output logic              signal_lost
);

  localparam logic [CNT_W-1:0] PER_LO = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] PER_HI = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] HI_LO  = CNT_W'(PULSE_MIN / 2);
  localparam logic [CNT_W-1:0] HI_HI  = CNT_W'(2 * PULSE_MAX);
  localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PULSE_MAX);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);

  logic             rise;
  logic             fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_stage;
  logic [CNT_W-1:0] per_stage;
  logic             accept_pending;
  logic             reject_pending;
  logic             in_range;
  logic             at_timeout;

  servo_pwm_capture_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign in_range   = (per_cnt >= PER_LO) && (per_cnt <= PER_HI) &&
                      (hi_cnt >= HI_LO) && (hi_cnt <= HI_HI);
  assign at_timeout = (per_cnt >= TMO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      hi_cnt         <= '0;
      per_cnt        <= '0;
      hi_stage       <= '0;
      per_stage      <= '0;
      accept_pending <= 1'b0;
      reject_pending <= 1'b0;
      pulse_width    <= OUT_W'(PULSE_MIN);
      period         <= OUT_W'(RESET_PERIOD);
      duty_code      <= DUTY_W'(DUTY_MIN);
      valid          <= 1'b0;
      err            <= 1'b0;
      signal_lost    <= 1'b1;
    end else if (!enable) begin
      // Data outputs hold; any stage-2 result still in flight is dropped.
      state          <= ST_IDLE;
      hi_cnt         <= '0;
      per_cnt        <= '0;
      accept_pending <= 1'b0;
      reject_pending <= 1'b0;
      valid          <= 1'b0;
      err            <= 1'b0;
      signal_lost    <= 1'b1;
    end else begin
      valid          <= accept_pending;
      err            <= reject_pending;
      accept_pending <= 1'b0;
      reject_pending <= 1'b0;

      if (accept_pending) begin
        pulse_width <= to_out(hi_stage);
        period      <= to_out(per_stage);
        duty_code   <= duty_map(hi_stage, P_MIN, P_MAX);
        signal_lost <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state   <= ST_HIGH;
            hi_cnt  <= CNT_W'(1);
            per_cnt <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (at_timeout) begin
            state       <= ST_IDLE;
            hi_cnt      <= '0;
            per_cnt     <= '0;
            signal_lost <= 1'b1;
          end else begin
            per_cnt <= sat_inc(per_cnt, TMO);
            if (fall) state <= ST_LOW;
            else      hi_cnt <= sat_inc(hi_cnt, TMO);
          end
        end
        ST_LOW: begin
          if (rise) begin
            // Closing edge of one period is the opening edge of the next.
            state          <= ST_HIGH;
            hi_cnt         <= CNT_W'(1);
            per_cnt        <= CNT_W'(1);
            hi_stage       <= hi_cnt;
            per_stage      <= per_cnt;
            accept_pending <= in_range;
            reject_pending <= ~in_range;
          end else if (at_timeout) begin
            state       <= ST_IDLE;
            hi_cnt      <= '0;
            per_cnt     <= '0;
            signal_lost <= 1'b1;
          end else begin
            per_cnt <= sat_inc(per_cnt, TMO);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
